// File: rtl/tx_sequencer.sv
// Sweep scheduler above the IR playback controller. It debounces the button, issues start requests,
// retries after controller failures and shares the delay timer. Optional sweep watchdog: SWEEP_WATCHDOG_EN.
module tx_sequencer #(
    parameter int          DELAY_BITS      = 16,
    parameter int          GAP_TICKS       = 20000,
    parameter int          DEBOUNCE_CYCLES = 50000,
    parameter int          MAX_RETRY       = 3,
    parameter logic [23:0] WATCHDOG_CYCLES = 24'hFFFFFF
) (
    input  logic                  clock_in,
    input  logic                  reset_n_in,
    input  logic                  button_in,
    input  logic                  loop_mode_in,
    input  logic                  abort_in,
    output logic                  ctl_reset_out,
    output logic                  ctl_start_out,
    input  logic                  ctl_busy_in,
    input  logic                  ctl_fail_in,
    input  logic                  ctl_delay_enable_in,
    input  logic                  ctl_delay_start_strobe_in,
    input  logic [DELAY_BITS-1:0] ctl_delay_value_in,
    output logic                  ctl_delay_busy_out,
    output logic                  dly_enable_out,
    output logic                  dly_start_strobe_out,
    output logic [DELAY_BITS-1:0] dly_value_out,
    input  logic                  dly_busy_in,
    output logic                  busy_out,
    output logic                  fail_out,
    output logic [7:0]            sweep_count_out
);

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_START, S_WAIT_BUSY, S_RUN, S_GAP, S_RECOVER, S_FAULT
    } state_t;

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    state_t          state;
    logic            btn_meta, btn_sync, btn_level, btn_level_d;
    logic [DB_W-1:0] db_cnt;
    logic            press;
    logic            rst_phase;
    logic [1:0]      wait_cnt;
    logic [7:0]      retry_cnt;
    logic            stop_req;
    logic            loop_latched;
    logic            gap_seen;
    logic            wd_expired;

    // The filtered level only flips once the synchronized input has disagreed with it for the full window.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            btn_meta    <= 1'b0;
            btn_sync    <= 1'b0;
            btn_level   <= 1'b0;
            btn_level_d <= 1'b0;
            db_cnt      <= '0;
        end else begin
            btn_meta    <= button_in;
            btn_sync    <= btn_meta;
            btn_level_d <= btn_level;
            if (btn_sync == btn_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_level <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign press = btn_level & ~btn_level_d;

`ifdef SWEEP_WATCHDOG_EN
    logic [23:0] wd_cnt;

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            wd_cnt <= '0;
        end else if (state == S_START) begin
            wd_cnt <= '0;
        end else if (state == S_WAIT_BUSY || state == S_RUN) begin
            wd_cnt <= wd_cnt + 24'd1;
        end
    end

    assign wd_expired = (state == S_WAIT_BUSY || state == S_RUN) && (wd_cnt == WATCHDOG_CYCLES - 24'd1);
`else
    logic unused_wd;
    assign unused_wd  = ^WATCHDOG_CYCLES;
    assign wd_expired = 1'b0;
`endif

    // Outputs are registered to match the state being entered; abort reuses the S_INIT reset pulse.
    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state           <= S_INIT;
            rst_phase       <= 1'b0;
            wait_cnt        <= '0;
            retry_cnt       <= '0;
            stop_req        <= 1'b0;
            loop_latched    <= 1'b0;
            gap_seen        <= 1'b0;
            sweep_count_out <= '0;
            ctl_reset_out   <= 1'b1;
            ctl_start_out   <= 1'b0;
            busy_out        <= 1'b0;
            fail_out        <= 1'b0;
        end else begin
            ctl_start_out <= 1'b0;
            ctl_reset_out <= 1'b0;
            busy_out      <= 1'b1;
            fail_out      <= 1'b0;
            if (abort_in && state != S_INIT) begin
                state         <= S_INIT;
                rst_phase     <= 1'b0;
                ctl_reset_out <= 1'b1;
                retry_cnt     <= '0;
                stop_req      <= 1'b0;
            end else begin
                case (state)
                    S_INIT: begin
                        if (!rst_phase) begin
                            rst_phase     <= 1'b1;
                            ctl_reset_out <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            busy_out <= 1'b0;
                        end
                    end
                    S_IDLE: begin
                        if (press) begin
                            state         <= S_START;
                            ctl_start_out <= 1'b1;
                            retry_cnt     <= '0;
                            stop_req      <= 1'b0;
                        end else begin
                            busy_out <= 1'b0;
                        end
                    end
                    S_START: begin
                        state        <= S_WAIT_BUSY;
                        loop_latched <= loop_mode_in;
                        wait_cnt     <= '0;
                    end
                    S_WAIT_BUSY: begin
                        if (wd_expired || (!ctl_busy_in && wait_cnt == 2'd3)) begin
                            state         <= S_RECOVER;
                            rst_phase     <= 1'b0;
                            ctl_reset_out <= 1'b1;
                        end else if (ctl_busy_in) begin
                            state <= S_RUN;
                        end else begin
                            wait_cnt <= wait_cnt + 2'd1;
                        end
                    end
                    S_RUN: begin
                        if (ctl_fail_in || wd_expired) begin
                            state         <= S_RECOVER;
                            rst_phase     <= 1'b0;
                            ctl_reset_out <= 1'b1;
                        end else if (!ctl_busy_in) begin
                            sweep_count_out <= sweep_count_out + 8'd1;
                            retry_cnt       <= '0;
                            if (loop_latched && !(stop_req || press)) begin
                                state    <= S_GAP;
                                gap_seen <= 1'b0;
                            end else begin
                                state    <= S_IDLE;
                                busy_out <= 1'b0;
                            end
                        end else if (press) begin
                            stop_req <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (GAP_TICKS == 0 || (gap_seen && !dly_busy_in)) begin
                            if (stop_req || press) begin
                                state    <= S_IDLE;
                                busy_out <= 1'b0;
                            end else begin
                                state         <= S_START;
                                ctl_start_out <= 1'b1;
                            end
                        end else begin
                            if (dly_busy_in) gap_seen <= 1'b1;
                            if (press) stop_req <= 1'b1;
                        end
                    end
                    S_RECOVER: begin
                        if (!rst_phase) begin
                            rst_phase     <= 1'b1;
                            ctl_reset_out <= 1'b1;
                        end else begin
                            retry_cnt <= retry_cnt + 8'd1;
                            if ((9'(retry_cnt) + 9'd1) < 9'(MAX_RETRY)) begin
                                state         <= S_START;
                                ctl_start_out <= 1'b1;
                            end else begin
                                state    <= S_FAULT;
                                busy_out <= 1'b0;
                                fail_out <= 1'b1;
                            end
                        end
                    end
                    S_FAULT: begin
                        busy_out <= 1'b0;
                        fail_out <= 1'b1;
                    end
                    default: begin
                        state     <= S_INIT;
                        rst_phase <= 1'b0;
                    end
                endcase
            end
        end
    end

    // The controller owns the delay timer while a sweep is in flight; the sequencer owns it during the gap.
    always_comb begin
        dly_enable_out       = 1'b0;
        dly_start_strobe_out = 1'b0;
        dly_value_out        = '0;
        ctl_delay_busy_out   = 1'b0;
        case (state)
            S_WAIT_BUSY, S_RUN: begin
                dly_enable_out       = ctl_delay_enable_in;
                dly_start_strobe_out = ctl_delay_start_strobe_in;
                dly_value_out        = ctl_delay_value_in;
                ctl_delay_busy_out   = dly_busy_in;
            end
            S_GAP: begin
                dly_enable_out       = 1'b1;
                dly_start_strobe_out = !gap_seen && (GAP_TICKS != 0);
                dly_value_out        = DELAY_BITS'(GAP_TICKS);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_tx_sequencer.sv
// Directed bench for tx_sequencer with small debounce/gap parameters and simple models
// of the playback controller and the delay timer.
module tb_tx_sequencer;

    localparam int DB  = 8;
    localparam int GAP = 20;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        button = 1'b0;
    logic        loop_mode = 1'b0;
    logic        abort = 1'b0;
    logic        ctl_busy = 1'b0;
    logic        ctl_fail = 1'b0;
    logic        ctl_delay_enable = 1'b0;
    logic        ctl_delay_strobe = 1'b0;
    logic [15:0] ctl_delay_value = 16'd0;
    logic        dly_busy = 1'b0;

    logic        ctl_reset_out, ctl_start_out, ctl_delay_busy_out;
    logic        dly_enable_out, dly_start_strobe_out;
    logic [15:0] dly_value_out;
    logic        busy_out, fail_out;
    logic [7:0]  sweep_count_out;

    int checks = 0;
    int failures = 0;

    // model controls
    int run_len = 100;
    bit ctl_hold = 1'b0;
    bit fail_mode = 1'b0;
    bit timer_auto = 1'b1;
    int run_left = 0;
    int tmr_left = 0;
    int strobe_wait = 0;

    // observations
    int cycle = 0;
    int n_start, start_double, n_reset_pulses, rst_len, rst_len_bad;
    int n_strobe, strobe_val_bad, gap_bad, n_gap_starts, fall_cycle;
    bit prev_start, prev_reset, gap_fall_valid;

    typedef struct {
        logic        en;
        logic        strobe;
        logic [15:0] value;
        logic        dbusy;
        logic        exp_en;
        logic        exp_strobe;
        logic [15:0] exp_value;
        logic        exp_cbusy;
    } mux_vec_t;

    mux_vec_t vecs [4];

    tx_sequencer #(
        .DELAY_BITS(16),
        .GAP_TICKS(GAP),
        .DEBOUNCE_CYCLES(DB),
        .MAX_RETRY(3)
    ) dut (
        .clock_in(clock),
        .reset_n_in(reset_n),
        .button_in(button),
        .loop_mode_in(loop_mode),
        .abort_in(abort),
        .ctl_reset_out(ctl_reset_out),
        .ctl_start_out(ctl_start_out),
        .ctl_busy_in(ctl_busy),
        .ctl_fail_in(ctl_fail),
        .ctl_delay_enable_in(ctl_delay_enable),
        .ctl_delay_start_strobe_in(ctl_delay_strobe),
        .ctl_delay_value_in(ctl_delay_value),
        .ctl_delay_busy_out(ctl_delay_busy_out),
        .dly_enable_out(dly_enable_out),
        .dly_start_strobe_out(dly_start_strobe_out),
        .dly_value_out(dly_value_out),
        .dly_busy_in(dly_busy),
        .busy_out(busy_out),
        .fail_out(fail_out),
        .sweep_count_out(sweep_count_out)
    );

    always #5 clock = ~clock;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        n_start = 0; start_double = 0; n_reset_pulses = 0; rst_len = 0; rst_len_bad = 0;
        n_strobe = 0; strobe_val_bad = 0; gap_bad = 0; n_gap_starts = 0; fall_cycle = 0;
        prev_start = ctl_start_out; prev_reset = ctl_reset_out; gap_fall_valid = 1'b0;
    endtask

    // One clock: observe outputs just after the edge, then let the controller and timer models react.
    task automatic tick();
        @(posedge clock);
        #1;
        cycle++;
        if (ctl_start_out) begin
            n_start++;
            if (prev_start) start_double++;
            if (gap_fall_valid) begin
                n_gap_starts++;
                if (cycle - fall_cycle != 1) gap_bad++;
                gap_fall_valid = 1'b0;
            end
        end
        if (dly_start_strobe_out) begin
            n_strobe++;
            if (dly_value_out != 16'(GAP)) strobe_val_bad++;
        end
        if (ctl_reset_out) begin
            rst_len++;
            if (!prev_reset) n_reset_pulses++;
        end else if (prev_reset) begin
            if (rst_len != 2) rst_len_bad++;
            rst_len = 0;
        end
        prev_start = ctl_start_out;
        prev_reset = ctl_reset_out;

        if (ctl_reset_out) begin
            ctl_busy = 1'b0;
            ctl_fail = 1'b0;
            run_left = 0;
        end else if (ctl_start_out) begin
            ctl_busy = 1'b1;
            run_left = run_len;
        end else if (ctl_busy && !ctl_hold && !ctl_fail) begin
            if (run_left > 0) run_left--;
            if (run_left == 0) begin
                if (fail_mode) ctl_fail = 1'b1;
                else ctl_busy = 1'b0;
            end
        end

        if (timer_auto) begin
            if (dly_busy) begin
                if (tmr_left > 0) tmr_left--;
                if (tmr_left == 0) begin
                    dly_busy = 1'b0;
                    fall_cycle = cycle;
                    gap_fall_valid = 1'b1;
                end
            end else if (dly_enable_out && dly_start_strobe_out) begin
                strobe_wait++;
                if (strobe_wait == 3) begin
                    dly_busy = 1'b1;
                    tmr_left = int'(dly_value_out);
                    strobe_wait = 0;
                end
            end else begin
                strobe_wait = 0;
            end
        end
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        button = 1'b0;
        abort = 1'b0;
        ctl_busy = 1'b0;
        ctl_fail = 1'b0;
        dly_busy = 1'b0;
        strobe_wait = 0;
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (4) tick();
        clear_obs();
    endtask

    task automatic press_button(input int hold);
        button = 1'b1;
        repeat (hold) tick();
        button = 1'b0;
    endtask

    task automatic apply_stimulus(input mux_vec_t v);
        ctl_delay_enable = v.en;
        ctl_delay_strobe = v.strobe;
        ctl_delay_value  = v.value;
        dly_busy         = v.dbusy;
        #1;
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 1'b1, 16'h1234, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'hABCD, 1'b1, 1'b1, 1'b0, 16'hABCD, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0};

        // reset values while reset is held
        clear_obs();
        repeat (2) tick();
        check_output("rst_ctl_reset", ctl_reset_out, 1);
        check_output("rst_ctl_start", ctl_start_out, 0);
        check_output("rst_busy", busy_out, 0);
        check_output("rst_fail", fail_out, 0);
        check_output("rst_count", sweep_count_out, 0);
        check_output("rst_dly_enable", dly_enable_out, 0);
        reset_n = 1'b1;
        repeat (4) tick();
        check_output("idle_ctl_reset", ctl_reset_out, 0);
        check_output("idle_busy", busy_out, 0);
        clear_obs();

        // debounce: one cycle short, then exactly long enough
        press_button(DB - 1);
        repeat (20) tick();
        check_output("debounce_short", n_start, 0);
        ctl_hold = 1'b1;
        run_len = 100;
        timer_auto = 1'b0;
        press_button(DB);
        for (int i = 0; i < 30 && n_start < 1; i++) tick();
        check_output("debounce_start", n_start, 1);
        repeat (10) tick();
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
            check_output("run_dly_enable", dly_enable_out, vecs[i].exp_en);
            check_output("run_dly_strobe", dly_start_strobe_out, vecs[i].exp_strobe);
            check_output("run_dly_value", dly_value_out, vecs[i].exp_value);
            check_output("run_ctl_dbusy", ctl_delay_busy_out, vecs[i].exp_cbusy);
        end
        apply_stimulus('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0});
        ctl_hold = 1'b0;
        for (int i = 0; i < 300 && busy_out !== 1'b0; i++) tick();
        check_output("single_sweep_idle", busy_out, 0);
        check_output("single_sweep_count", sweep_count_out, 1);
        check_output("single_start_once", n_start, 1);
        check_output("start_one_cycle", start_double, 0);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i]);
            check_output("idle_dly_enable", dly_enable_out, 0);
            check_output("idle_dly_strobe", dly_start_strobe_out, 0);
            check_output("idle_dly_value", dly_value_out, 0);
            check_output("idle_ctl_dbusy", ctl_delay_busy_out, 0);
        end
        apply_stimulus('{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0});
        timer_auto = 1'b1;

        // loop mode with gaps, stop requested during sweep 3
        apply_reset();
        loop_mode = 1'b1;
        run_len = 30;
        press_button(DB);
        for (int i = 0; i < 400 && n_start < 3; i++) tick();
        check_output("loop_third_start", n_start, 3);
        press_button(DB);
        for (int i = 0; i < 200 && busy_out !== 1'b0; i++) tick();
        check_output("loop_stop_idle", busy_out, 0);
        check_output("loop_count", sweep_count_out, 3);
        check_output("loop_starts", n_start, 3);
        check_output("gap_strobe_cycles", n_strobe, 6);
        check_output("gap_strobe_value", strobe_val_bad, 0);
        check_output("gap_starts", n_gap_starts, 2);
        check_output("gap_start_latency", gap_bad, 0);
        loop_mode = 1'b0;

        // every sweep fails: three recovery pulses then fault, abort clears it
        apply_reset();
        fail_mode = 1'b1;
        run_len = 5;
        press_button(DB);
        for (int i = 0; i < 200 && fail_out !== 1'b1; i++) tick();
        check_output("fault_fail", fail_out, 1);
        check_output("fault_busy", busy_out, 0);
        check_output("fault_reset_pulses", n_reset_pulses, 3);
        check_output("fault_pulse_len", rst_len_bad, 0);
        check_output("fault_starts", n_start, 3);
        check_output("fault_count", sweep_count_out, 0);
        fail_mode = 1'b0;
        press_button(DB);
        repeat (6) tick();
        check_output("fault_press_ignored", n_start, 3);
        check_output("fault_held", fail_out, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        check_output("abort_fail_clear", fail_out, 0);
        check_output("abort_idle", busy_out, 0);
        check_output("abort_reset_pulses", n_reset_pulses, 4);
        check_output("abort_pulse_len", rst_len_bad, 0);

        // abort in the same cycle busy falls: no count
        apply_reset();
        ctl_hold = 1'b1;
        press_button(DB);
        for (int i = 0; i < 30 && n_start < 1; i++) tick();
        repeat (5) tick();
        ctl_busy = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        repeat (4) tick();
        check_output("abort_run_count", sweep_count_out, 0);
        check_output("abort_run_pulses", n_reset_pulses, 1);
        check_output("abort_run_len", rst_len_bad, 0);
        check_output("abort_run_idle", busy_out, 0);

        // fail and busy fall together: fail wins, retried sweep then completes
        clear_obs();
        press_button(DB);
        for (int i = 0; i < 30 && n_start < 1; i++) tick();
        repeat (5) tick();
        ctl_busy = 1'b0;
        ctl_fail = 1'b1;
        ctl_hold = 1'b0;
        run_len = 5;
        tick();
        for (int i = 0; i < 100 && busy_out !== 1'b0; i++) tick();
        check_output("failwin_count", sweep_count_out, 1);
        check_output("failwin_pulses", n_reset_pulses, 1);
        check_output("failwin_starts", n_start, 2);

        // asynchronous reset in the middle of a gap
        apply_reset();
        loop_mode = 1'b1;
        run_len = 5;
        press_button(DB);
        for (int i = 0; i < 200 && dly_enable_out !== 1'b1; i++) tick();
        check_output("gap_reached", dly_enable_out, 1);
        reset_n = 1'b0;
        #1;
        check_output("midgap_ctl_reset", ctl_reset_out, 1);
        check_output("midgap_ctl_start", ctl_start_out, 0);
        check_output("midgap_busy", busy_out, 0);
        check_output("midgap_fail", fail_out, 0);
        check_output("midgap_count", sweep_count_out, 0);
        check_output("midgap_dly_enable", dly_enable_out, 0);
        check_output("midgap_dly_strobe", dly_start_strobe_out, 0);
        check_output("midgap_dly_value", dly_value_out, 0);
        check_output("midgap_ctl_dbusy", ctl_delay_busy_out, 0);
        loop_mode = 1'b0;
        apply_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
